// File: rtl/axi_crossbar_wdata_route.sv
// AXI4 crossbar W-channel steering: queues write commands and forwards one W burst per command
// to the selected master, or drops it on decode error. Optional macro: AXI_WDATA_REG_EN (master-side skid register).
module axi_crossbar_wdata_route #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int WUSER_WIDTH = 1,
  parameter int CMD_DEPTH   = 4,
  localparam int SEL_W      = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SEL_W-1:0]       s_wc_select,
  input  logic                   s_wc_decerr,
  input  logic                   s_wc_valid,
  output logic                   s_wc_ready,
  input  logic [DATA_WIDTH-1:0]  s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]  s_axi_wstrb,
  input  logic                   s_axi_wlast,
  input  logic [WUSER_WIDTH-1:0] s_axi_wuser,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [DATA_WIDTH-1:0]  m_axi_wdata,
  output logic [STRB_WIDTH-1:0]  m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic [WUSER_WIDTH-1:0] m_axi_wuser,
  output logic [M_COUNT-1:0]     m_axi_wvalid,
  input  logic [M_COUNT-1:0]     m_axi_wready,
  output logic                   m_wdone_valid,
  output logic                   m_wdone_decerr
);

  localparam int PTR_W = $clog2(CMD_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUTE,
    ST_DISCARD
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic             r_wdone_valid;
  logic             r_wdone_decerr;

  logic [SEL_W:0]   r_cmd_mem [CMD_DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             r_wc_ready;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full_nxt;
  logic             w_drain_ok;
  logic             w_s_hs;
  logic             w_out_last_hs;
  logic [PTR_W:0]   w_wr_ptr_nxt;
  logic [PTR_W:0]   w_rd_ptr_nxt;
  logic [SEL_W:0]   w_head;

  // Command FIFO: extra pointer MSB distinguishes full from empty
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_push       = s_wc_valid && r_wc_ready;
  assign w_pop        = (r_state == ST_IDLE) && !w_empty && w_drain_ok;
  assign w_wr_ptr_nxt = r_wr_ptr + (PTR_W + 1)'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + (PTR_W + 1)'(w_pop);
  assign w_full_nxt   = (w_wr_ptr_nxt[PTR_W] != w_rd_ptr_nxt[PTR_W]) &&
                        (w_wr_ptr_nxt[PTR_W-1:0] == w_rd_ptr_nxt[PTR_W-1:0]);
  assign w_head       = r_cmd_mem[r_rd_ptr[PTR_W-1:0]];
  assign s_wc_ready   = r_wc_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_cmd_mem[r_wr_ptr[PTR_W-1:0]] <= {s_wc_decerr, s_wc_select};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wc_ready <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_wc_ready <= !w_full_nxt;
    end
  end

  assign w_s_hs = s_axi_wvalid && s_axi_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_sel          <= '0;
      r_wdone_valid  <= 1'b0;
      r_wdone_decerr <= 1'b0;
    end else begin
      r_wdone_valid  <= 1'b0;
      r_wdone_decerr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_sel   <= w_head[SEL_W-1:0];
            r_state <= w_head[SEL_W] ? ST_DISCARD : ST_ROUTE;
          end
        end
        ST_ROUTE: begin
          if (w_s_hs && s_axi_wlast) begin
            r_state <= ST_IDLE;
`ifndef AXI_WDATA_REG_EN
            r_wdone_valid <= 1'b1;
`endif
          end
        end
        ST_DISCARD: begin
          if (s_axi_wvalid && s_axi_wlast) begin
            r_state        <= ST_IDLE;
            r_wdone_valid  <= 1'b1;
            r_wdone_decerr <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // With the output register, completion is signalled when the last beat leaves it
      if (w_out_last_hs) begin
        r_wdone_valid <= 1'b1;
      end
    end
  end

  assign m_wdone_valid  = r_wdone_valid;
  assign m_wdone_decerr = r_wdone_decerr;

`ifndef AXI_WDATA_REG_EN

  assign w_drain_ok    = 1'b1;
  assign w_out_last_hs = 1'b0;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;
  assign m_axi_wuser   = s_axi_wuser;

  always_comb begin
    m_axi_wvalid = '0;
    s_axi_wready = 1'b0;
    case (r_state)
      ST_ROUTE: begin
        m_axi_wvalid[r_sel] = s_axi_wvalid;
        s_axi_wready        = m_axi_wready[r_sel];
      end
      ST_DISCARD: s_axi_wready = 1'b1;
      default: ;
    endcase
  end

`else

  localparam int BEAT_W = WUSER_WIDTH + 1 + STRB_WIDTH + DATA_WIDTH;

  logic              r_out_valid;
  logic              r_tmp_valid;
  logic              r_s_ready;
  logic [BEAT_W-1:0] r_out_beat;
  logic [BEAT_W-1:0] r_tmp_beat;
  logic [BEAT_W-1:0] w_in_beat;
  logic              w_m_ready;
  logic              w_in_valid;
  logic              w_s_ready_early;

  assign w_in_beat       = {s_axi_wuser, s_axi_wlast, s_axi_wstrb, s_axi_wdata};
  assign w_m_ready       = m_axi_wready[r_sel];
  assign w_in_valid      = (r_state == ST_ROUTE) && s_axi_wvalid && r_s_ready;
  // Ready stays high unless the skid slot would be needed and is already occupied
  assign w_s_ready_early = w_m_ready || (!r_tmp_valid && (!r_out_valid || !w_in_valid));
  assign w_out_last_hs   = r_out_valid && w_m_ready && r_out_beat[DATA_WIDTH+STRB_WIDTH];
  // r_sel must not change while a beat for the previous master is still held
  assign w_drain_ok      = !r_out_valid && !r_tmp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_tmp_valid <= 1'b0;
      r_s_ready   <= 1'b0;
    end else begin
      r_s_ready <= w_s_ready_early;
      if (r_s_ready) begin
        if (w_m_ready || !r_out_valid) begin
          r_out_valid <= w_in_valid;
        end else if (w_in_valid) begin
          r_tmp_valid <= 1'b1;
        end
      end else if (w_m_ready) begin
        r_out_valid <= r_tmp_valid;
        r_tmp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_s_ready) begin
      if (w_m_ready || !r_out_valid) begin
        r_out_beat <= w_in_beat;
      end else begin
        r_tmp_beat <= w_in_beat;
      end
    end else if (w_m_ready) begin
      r_out_beat <= r_tmp_beat;
    end
  end

  assign m_axi_wdata = r_out_beat[DATA_WIDTH-1:0];
  assign m_axi_wstrb = r_out_beat[DATA_WIDTH +: STRB_WIDTH];
  assign m_axi_wlast = r_out_beat[DATA_WIDTH+STRB_WIDTH];
  assign m_axi_wuser = r_out_beat[BEAT_W-1 -: WUSER_WIDTH];

  always_comb begin
    m_axi_wvalid        = '0;
    m_axi_wvalid[r_sel] = r_out_valid;
    s_axi_wready        = 1'b0;
    case (r_state)
      ST_ROUTE:   s_axi_wready = r_s_ready;
      ST_DISCARD: s_axi_wready = 1'b1;
      default: ;
    endcase
  end

`endif

endmodule

// File: tb/tb_axi_crossbar_wdata_route.sv
// Directed bench for axi_crossbar_wdata_route: queued commands, routed/discarded bursts,
// FIFO full, ready toggling, back-to-back bubble and mid-burst reset, checked via scoreboard queues.
module tb_axi_crossbar_wdata_route;

  localparam int M_COUNT     = 4;
  localparam int DATA_WIDTH  = 32;
  localparam int STRB_WIDTH  = 4;
  localparam int WUSER_WIDTH = 1;
  localparam int CMD_DEPTH   = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [1:0]             s_wc_select;
  logic                   s_wc_decerr;
  logic                   s_wc_valid;
  logic                   s_wc_ready;
  logic [DATA_WIDTH-1:0]  s_axi_wdata;
  logic [STRB_WIDTH-1:0]  s_axi_wstrb;
  logic                   s_axi_wlast;
  logic [WUSER_WIDTH-1:0] s_axi_wuser;
  logic                   s_axi_wvalid;
  logic                   s_axi_wready;
  logic [DATA_WIDTH-1:0]  m_axi_wdata;
  logic [STRB_WIDTH-1:0]  m_axi_wstrb;
  logic                   m_axi_wlast;
  logic [WUSER_WIDTH-1:0] m_axi_wuser;
  logic [M_COUNT-1:0]     m_axi_wvalid;
  logic [M_COUNT-1:0]     m_axi_wready;
  logic                   m_wdone_valid;
  logic                   m_wdone_decerr;

  axi_crossbar_wdata_route #(
    .M_COUNT    (M_COUNT),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .WUSER_WIDTH(WUSER_WIDTH),
    .CMD_DEPTH  (CMD_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_wc_select   (s_wc_select),
    .s_wc_decerr   (s_wc_decerr),
    .s_wc_valid    (s_wc_valid),
    .s_wc_ready    (s_wc_ready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wuser   (s_axi_wuser),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wuser   (m_axi_wuser),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_wdone_valid (m_wdone_valid),
    .m_wdone_decerr(m_wdone_decerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  oh;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic        user;
  } beat_t;

  beat_t q_beat[$];
  logic  q_done[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every master-side handshake and every completion pulse pops one entry
  beat_t mon_b;
  logic  mon_d;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axi_wvalid != '0) begin
        if (q_beat.size() == 0) begin
          chk("unexpected_wvalid", 64'(m_axi_wvalid), 64'(0));
        end else begin
          chk("wvalid_target", 64'(m_axi_wvalid), 64'(q_beat[0].oh));
          if ((m_axi_wvalid & m_axi_wready) != '0) begin
            mon_b = q_beat.pop_front();
            chk("w_data", 64'(m_axi_wdata), 64'(mon_b.data));
            chk("w_strb", 64'(m_axi_wstrb), 64'(mon_b.strb));
            chk("w_last", 64'(m_axi_wlast), 64'(mon_b.last));
            chk("w_user", 64'(m_axi_wuser), 64'(mon_b.user));
          end
        end
      end
      if (m_wdone_valid) begin
        if (q_done.size() == 0) begin
          chk("unexpected_wdone", 64'(m_wdone_valid), 64'(0));
        end else begin
          mon_d = q_done.pop_front();
          chk("wdone_decerr_sb", 64'(m_wdone_decerr), 64'(mon_d));
        end
      end
    end
  end

  task automatic push_cmd(input logic [1:0] sel, input logic derr);
    int n = 0;
    s_wc_select = sel;
    s_wc_decerr = derr;
    s_wc_valid  = 1'b1;
    q_done.push_back(derr);
    @(negedge clk);
    while (!s_wc_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("cmd_accept", 64'(s_wc_ready), 64'(1));
    @(posedge clk); #1;
    s_wc_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [3:0] oh,
                           output int waits);
    int n = 0;
    s_axi_wdata = d;
    s_axi_wstrb = d[7:4];
    s_axi_wlast = last;
    s_axi_wuser = d[0];
    if (oh != 4'd0) q_beat.push_back('{oh, d, d[7:4], last, d[0]});
    s_axi_wvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_wready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("beat_accept", 64'(s_axi_wready), 64'(1));
    chk("beat_wvalid", 64'(m_axi_wvalid), 64'(oh));
    waits = n;
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
  endtask

  task automatic expect_done(input logic derr);
    @(negedge clk);
    chk("wdone_valid", 64'(m_wdone_valid), 64'(1));
    chk("wdone_decerr", 64'(m_wdone_decerr), 64'(derr));
    @(posedge clk); #1;
    @(negedge clk);
    chk("wdone_pulse_width", 64'(m_wdone_valid), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  int   w;
  int   k;
  int   c;
  int   driven;
  logic hs;
  logic pat [4];

  initial begin
    s_wc_select  = '0;
    s_wc_decerr  = 1'b0;
    s_wc_valid   = 1'b0;
    s_axi_wdata  = '0;
    s_axi_wstrb  = '0;
    s_axi_wlast  = 1'b0;
    s_axi_wuser  = '0;
    s_axi_wvalid = 1'b0;
    m_axi_wready = '1;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wc_ready", 64'(s_wc_ready), 64'(0));
    chk("rst_s_wready", 64'(s_axi_wready), 64'(0));
    chk("rst_m_wvalid", 64'(m_axi_wvalid), 64'(0));
    chk("rst_wdone", 64'(m_wdone_valid), 64'(0));
    chk("rst_wdone_decerr", 64'(m_wdone_decerr), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_wc_ready", 64'(s_wc_ready), 64'(1));
    @(posedge clk); #1;

    // A is popped into ROUTE; B..E fill all four FIFO entries
    push_cmd(2'd1, 1'b0);
    push_cmd(2'd0, 1'b0);
    push_cmd(2'd3, 1'b0);
    push_cmd(2'd0, 1'b1);
    push_cmd(2'd2, 1'b0);
    @(negedge clk);
    chk("fifo_full_ready", 64'(s_wc_ready), 64'(0));
    @(posedge clk); #1;

    // Finish A; ready returns only after the next pop
    send_beat(32'h0000_A0A1, 1'b1, 4'b0010, w);
    @(negedge clk);
    chk("full_ready_before_pop", 64'(s_wc_ready), 64'(0));
    @(negedge clk);
    chk("full_ready_after_pop", 64'(s_wc_ready), 64'(1));
    @(posedge clk); #1;

    // Back-to-back one-beat bursts sel=0 then sel=3: one IDLE bubble
    send_beat(32'h0000_B0B0, 1'b1, 4'b0001, w);
    chk("b2b_first_wait", 64'(w), 64'(0));
    send_beat(32'h0000_C3C3, 1'b1, 4'b1000, w);
    chk("b2b_bubble", 64'(w), 64'(1));

    // Decode-error burst of 3 beats is absorbed
    send_beat(32'h0000_D001, 1'b0, 4'b0000, w);
    send_beat(32'h0000_D002, 1'b0, 4'b0000, w);
    chk("discard_throughput", 64'(w), 64'(0));
    send_beat(32'h0000_D003, 1'b1, 4'b0000, w);
    expect_done(1'b1);

    // sel=2, 4-beat burst 0x11..0x44 at full throughput
    for (int i = 1; i <= 4; i++) begin
      send_beat(32'h11 * i, (i == 4), 4'b0100, w);
      chk("route_throughput", 64'(w), 64'(0));
    end
    expect_done(1'b0);

    // sel=1 with m_axi_wready[1] toggling 1,0,0,1
    push_cmd(2'd1, 1'b0);
    @(posedge clk); #1;
    k = 0;
    c = 0;
    driven = -1;
    while (k < 4 && c < 40) begin
      if (driven != k) begin
        s_axi_wdata = 32'h0000_E0F0 + k;
        s_axi_wstrb = 4'(k + 1);
        s_axi_wlast = (k == 3);
        s_axi_wuser = 1'(k);
        q_beat.push_back('{4'b0010, 32'h0000_E0F0 + k, 4'(k + 1), (k == 3), 1'(k)});
        driven = k;
      end
      s_axi_wvalid    = 1'b1;
      m_axi_wready[1] = pat[c % 4];
      @(negedge clk);
      chk("wready_mirror", 64'(s_axi_wready), 64'(pat[c % 4]));
      hs = s_axi_wready;
      @(posedge clk); #1;
      if (hs) k++;
      c++;
    end
    s_axi_wvalid = 1'b0;
    m_axi_wready = '1;
    chk("toggle_beats", 64'(k), 64'(4));
    expect_done(1'b0);

    // Reset in the middle of a routed burst with a second command queued
    push_cmd(2'd2, 1'b0);
    push_cmd(2'd0, 1'b0);
    send_beat(32'h0000_0055, 1'b0, 4'b0100, w);
    send_beat(32'h0000_0066, 1'b0, 4'b0100, w);
    q_beat.delete();
    q_done.delete();
    s_axi_wdata  = 32'h0000_0077;
    s_axi_wlast  = 1'b0;
    s_axi_wvalid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_m_wvalid", 64'(m_axi_wvalid), 64'(0));
    chk("midrst_s_wready", 64'(s_axi_wready), 64'(0));
    chk("midrst_wdone", 64'(m_wdone_valid), 64'(0));
    repeat (3) begin
      @(negedge clk);
      chk("midrst_fifo_empty", 64'(s_axi_wready), 64'(0));
    end
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    push_cmd(2'd3, 1'b0);
    send_beat(32'h0000_0088, 1'b0, 4'b1000, w);
    send_beat(32'h0000_0099, 1'b1, 4'b1000, w);
    expect_done(1'b0);

    repeat (3) @(posedge clk);
    chk("beats_outstanding", 64'(q_beat.size()), 64'(0));
    chk("dones_outstanding", 64'(q_done.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
